// File: rtl/fifo_merge_reader_pkg.sv
// Shared types for the two-run merge reader: FSM state encoding and run-length width.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_merge_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MERGE   = 3'd1,
        ST_DRAIN_A = 3'd2,
        ST_DRAIN_B = 3'd3,
        ST_DONE    = 3'd4
    } merge_state_e;

    // A run may hold the full 2**LOG2_DEPTH entries, so one extra bit is needed.
    function automatic int run_len_w(input int log2_depth);
        return log2_depth + 1;
    endfunction

endpackage

// File: rtl/fifo_merge_reader_merge_select.sv
// Combinational compare and pop-select between the two upstream FIFO heads.
// Latency: 0 cycles (pure combinational).
// Backpressure: no pop while out_full is high or the chosen side is empty or exhausted.
module merge_select
    import fifo_merge_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  merge_state_e            i_state,
    input  logic [DATA_WIDTH-1:0]   i_a_dcmp,
    input  logic                    i_a_empty,
    input  logic                    i_a_rem_nz,
    input  logic [DATA_WIDTH-1:0]   i_b_dcmp,
    input  logic                    i_b_empty,
    input  logic                    i_b_rem_nz,
    input  logic                    i_out_full,
    output logic                    o_a_pop,
    output logic                    o_b_pop
);

    logic w_a_ok;
    logic w_b_ok;
    logic w_a_le_b;

    assign w_a_ok   = ~i_a_empty & i_a_rem_nz;
    assign w_b_ok   = ~i_b_empty & i_b_rem_nz;
    // Ties go to A so equal keys keep their A-before-B order.
    assign w_a_le_b = (i_a_dcmp <= i_b_dcmp);

    always_comb begin
        o_a_pop = 1'b0;
        o_b_pop = 1'b0;
        if (!i_out_full) begin
            case (i_state)
                ST_MERGE: begin
                    if (w_a_ok && w_b_ok) begin
                        o_a_pop = w_a_le_b;
                        o_b_pop = ~w_a_le_b;
                    end
                end
                ST_DRAIN_A: o_a_pop = w_a_ok;
                ST_DRAIN_B: o_b_pop = w_b_ok;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_merge_reader.sv
// Merges two sorted runs of run_len elements from FIFOs A and B into one sorted output stream.
// Latency: out_wr_en/out_data one cycle after the pop; done one cycle after the last write.
// Backpressure: out_full or an empty source stalls the select; no pop is issued while stalled.
module fifo_merge_reader
    import fifo_merge_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_DEPTH = 16,
    localparam int RL_W      = run_len_w(LOG2_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [RL_W-1:0]         run_len,
    input  logic [DATA_WIDTH-1:0]   a_dcmp,
    input  logic                    a_empty,
    output logic                    a_rd_en,
    input  logic [DATA_WIDTH-1:0]   b_dcmp,
    input  logic                    b_empty,
    output logic                    b_rd_en,
    input  logic                    out_full,
    output logic                    out_wr_en,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [RL_W-1:0] REM_ONE = RL_W'(1);

    merge_state_e            r_state;
    merge_state_e            w_state_nxt;
    logic [RL_W-1:0]         r_a_rem;
    logic [RL_W-1:0]         r_b_rem;
    logic [RL_W-1:0]         w_a_rem_nxt;
    logic [RL_W-1:0]         w_b_rem_nxt;
    logic                    r_out_wr_en;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_done;
    logic                    w_a_pop;
    logic                    w_b_pop;
    logic                    w_a_rem_nz;
    logic                    w_b_rem_nz;

    assign w_a_rem_nz = (r_a_rem != '0);
    assign w_b_rem_nz = (r_b_rem != '0);

    merge_select #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge_select (
        .i_state    (r_state),
        .i_a_dcmp   (a_dcmp),
        .i_a_empty  (a_empty),
        .i_a_rem_nz (w_a_rem_nz),
        .i_b_dcmp   (b_dcmp),
        .i_b_empty  (b_empty),
        .i_b_rem_nz (w_b_rem_nz),
        .i_out_full (out_full),
        .o_a_pop    (w_a_pop),
        .o_b_pop    (w_b_pop)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_a_rem_nxt = r_a_rem;
        w_b_rem_nxt = r_b_rem;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_rem_nxt = run_len;
                    w_b_rem_nxt = run_len;
                    w_state_nxt = (run_len == '0) ? ST_DONE : ST_MERGE;
                end
            end
            ST_MERGE: begin
                if (w_a_pop) begin
                    w_a_rem_nxt = r_a_rem - REM_ONE;
                    if (r_a_rem == REM_ONE) begin
                        w_state_nxt = w_b_rem_nz ? ST_DRAIN_B : ST_DONE;
                    end
                end else if (w_b_pop) begin
                    w_b_rem_nxt = r_b_rem - REM_ONE;
                    if (r_b_rem == REM_ONE) begin
                        w_state_nxt = w_a_rem_nz ? ST_DRAIN_A : ST_DONE;
                    end
                end
            end
            ST_DRAIN_A: begin
                if (w_a_pop) begin
                    w_a_rem_nxt = r_a_rem - REM_ONE;
                    if (r_a_rem == REM_ONE) w_state_nxt = ST_DONE;
                end
            end
            ST_DRAIN_B: begin
                if (w_b_pop) begin
                    w_b_rem_nxt = r_b_rem - REM_ONE;
                    if (r_b_rem == REM_ONE) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_a_rem     <= '0;
            r_b_rem     <= '0;
            r_out_wr_en <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a_rem     <= w_a_rem_nxt;
            r_b_rem     <= w_b_rem_nxt;
            r_out_wr_en <= w_a_pop | w_b_pop;
            if (w_a_pop) begin
                r_out_data <= a_dcmp;
            end else if (w_b_pop) begin
                r_out_data <= b_dcmp;
            end
            r_done      <= (r_state == ST_DONE);
        end
    end

    assign a_rd_en   = w_a_pop;
    assign b_rd_en   = w_b_pop;
    assign out_wr_en = r_out_wr_en;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_merge_reader.sv
// Scoreboard bench for fifo_merge_reader: upstream FIFOs modelled as queues, expected stream
// from a plain stable two-way merge, monitor checks every write, latency and done timing.
module tb_fifo_merge_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] run_len;
    logic [31:0] a_dcmp, b_dcmp;
    logic        a_empty, b_empty, a_rd_en, b_rd_en;
    logic        out_full, out_wr_en, busy, done;
    logic [31:0] out_data;

    fifo_merge_reader dut (
        .clk(clk), .reset(reset), .start(start), .run_len(run_len),
        .a_dcmp(a_dcmp), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dcmp(b_dcmp), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] qa[$], qb[$], exp_q[$];
    int          pop_cyc_q[$];
    bit          a_hold = 1'b0, b_hold = 1'b0;
    int          cur_len = 0, wr_cnt = 0, last_wr = 0, done_cyc = 0;
    bit          done_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every write against the scoreboard and checks done timing.
    always @(negedge clk) begin
        if (reset) begin
            if (out_wr_en) begin
                wr_cnt++;
                last_wr = cyc;
                if (exp_q.size() == 0 || pop_cyc_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("write_latency", cyc, pop_cyc_q.pop_front() + 1);
                end
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("done_write_count", wr_cnt, 2 * cur_len);
                check("done_scoreboard_empty", exp_q.size(), 0);
                if (cur_len > 0) check("done_after_last_write", cyc, last_wr + 1);
            end
        end
    end

    task automatic drive_heads();
        a_empty = (qa.size() == 0) || a_hold;
        b_empty = (qb.size() == 0) || b_hold;
        a_dcmp  = (qa.size() != 0) ? qa[0] : 32'd0;
        b_dcmp  = (qb.size() != 0) ? qb[0] : 32'd0;
    endtask

    // One clock: sample pops at negedge, apply them and new stall pattern after posedge.
    // mode 0: never stall; 1: random stalls; 2: out_full for k=2..4, b_empty pulse at k=6.
    task automatic cycle_step(input int mode, input int k);
        bit pa, pb;
        @(negedge clk);
        pa = a_rd_en;
        pb = b_rd_en;
        if (pa || pb) begin
            check("single_pop", pa && pb, 0);
            check("no_pop_when_full", out_full, 0);
            if (pa) check("pop_a_not_empty", a_empty, 0);
            if (pb) check("pop_b_not_empty", b_empty, 0);
            pop_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (pa && qa.size() != 0) void'(qa.pop_front());
        if (pb && qb.size() != 0) void'(qb.pop_front());
        case (mode)
            1: begin
                out_full = ($urandom_range(0, 3) == 0);
                a_hold   = ($urandom_range(0, 5) == 0);
                b_hold   = ($urandom_range(0, 5) == 0);
            end
            2: begin
                out_full = (k >= 2 && k < 5);
                a_hold   = 1'b0;
                b_hold   = (k == 6);
            end
            default: begin
                out_full = 1'b0;
                a_hold   = 1'b0;
                b_hold   = 1'b0;
            end
        endcase
        drive_heads();
    endtask

    // Reference model: stable merge of the two loaded runs, A wins ties. Issues start.
    task automatic begin_merge(input int len, output int st);
        int i, j;
        i = 0;
        j = 0;
        while (i < len || j < len) begin
            if (j >= len || (i < len && qa[i] <= qb[j])) begin
                exp_q.push_back(qa[i]);
                i++;
            end else begin
                exp_q.push_back(qb[j]);
                j++;
            end
        end
        cur_len   = len;
        wr_cnt    = 0;
        done_seen = 1'b0;
        drive_heads();
        start   = 1'b1;
        run_len = 17'(len);
        st      = cyc;
    endtask

    task automatic run_merge(input int len, input int mode);
        int st, k;
        begin_merge(len, st);
        k = 0;
        while (!done_seen && k < 400) begin
            cycle_step(mode, k);
            if (k == 0) check("busy_after_start", busy, 1);
            k++;
        end
        if (!done_seen) check("done_timeout", 0, 1);
        if (mode == 0) check("done_cycle_from_start", done_cyc - st, 2 * len + 2);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("fifo_a_consumed", qa.size(), 0);
        check("fifo_b_consumed", qb.size(), 0);
        cycle_step(0, 99);
    endtask

    task automatic load_random(input int len);
        logic [31:0] va, vb;
        va = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 : 32'd0;
        vb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 : 32'd0;
        va = va + 32'($urandom_range(0, 5));
        vb = vb + 32'($urandom_range(0, 5));
        for (int i = 0; i < len; i++) begin
            qa.push_back(va);
            qb.push_back(vb);
            va = va + 32'($urandom_range(0, 4));
            vb = vb + 32'($urandom_range(0, 4));
        end
    endtask

    initial begin
        int st, k;
        reset    = 1'b0;
        start    = 1'b0;
        run_len  = '0;
        out_full = 1'b0;
        drive_heads();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_wr_en", out_wr_en, 0);
        check("reset_out_data", out_data, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_a_rd_en", a_rd_en, 0);
        check("reset_b_rd_en", b_rd_en, 0);
        reset = 1'b1;
        cycle_step(0, 99);

        qa = '{1, 3, 5, 7};  qb = '{2, 4, 6, 8};   run_merge(4, 0);
        qa = '{5, 5, 9};     qb = '{5, 6, 7};      run_merge(3, 0);
        qa = '{1, 2};        qb = '{10, 20};       run_merge(2, 0);
        qa = '{1, 3, 5, 7};  qb = '{2, 4, 6, 8};   run_merge(4, 2);
        run_merge(0, 0);

        // Reset in the middle of a merge, then a fresh merge.
        qa = '{10, 20, 30, 40}; qb = '{15, 25, 35, 45};
        begin_merge(4, st);
        k = 0;
        while (wr_cnt < 3 && k < 50) begin
            cycle_step(0, k);
            k++;
        end
        check("reached_three_writes", wr_cnt >= 3, 1);
        #2 reset = 1'b0;
        #1;
        check("midreset_out_wr_en", out_wr_en, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_done", done, 0);
        check("midreset_busy", busy, 0);
        check("midreset_a_rd_en", a_rd_en, 0);
        check("midreset_b_rd_en", b_rd_en, 0);
        qa.delete();
        qb.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        drive_heads();
        @(posedge clk);
        #1 reset = 1'b1;
        cycle_step(0, 99);
        qa = '{3, 4, 9, 9};  qb = '{1, 4, 8, 9};   run_merge(4, 0);

        for (int r = 0; r < 24; r++) begin
            int len;
            len = $urandom_range(1, 12);
            load_random(len);
            run_merge(len, r % 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
